// File: rtl/cordic_vectoring_engine_if.sv
// Request/result bundle for the CORDIC vectoring engine.
// master drives the operands and start; slave returns status and polar results.
interface cordic_vectoring_engine_if #(
   parameter int BIT_WIDTH = 32
);
   logic                        start;
   logic signed [BIT_WIDTH-1:0] x_in;
   logic signed [BIT_WIDTH-1:0] y_in;
   logic                        busy;
   logic                        done;
   logic [BIT_WIDTH+1:0]        mag_out;
   logic signed [BIT_WIDTH+1:0] angle_out;

   modport master (
      output start, x_in, y_in,
      input  busy, done, mag_out, angle_out
   );

   modport slave (
      input  start, x_in, y_in,
      output busy, done, mag_out, angle_out
   );
endinterface

// File: rtl/cordic_vectoring_engine.sv
// Iterative CORDIC vectoring engine: atan2(y,x) and magnitude, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a COMP state that scales the magnitude by ~1/K.
module cordic_vectoring_engine #(
   parameter int BIT_WIDTH  = 32,
   parameter int ITERATIONS = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   cordic_vectoring_engine_if.slave       bus,
   output logic [5:0]                     count,
   input  logic [63:0]                    di_ei_result
);

   localparam int W = BIT_WIDTH + 2;
   localparam logic [63:0]         HALF_PI_WORD = 64'hC90FDAA22168C000;
   localparam logic signed [W-1:0] HALF_PI      = {2'b00, HALF_PI_WORD[63 -: BIT_WIDTH]};
   localparam logic [5:0]          LAST         = 6'(ITERATIONS - 1);

   generate
      if (ITERATIONS < 1 || ITERATIONS > 64) begin : g_bad_iterations
         $error("cordic_vectoring_engine: ITERATIONS must be in 1..64");
      end
      if (BIT_WIDTH < 64) begin : g_lut_tail
         logic unused_lut_tail;
         assign unused_lut_tail = ^di_ei_result[63-BIT_WIDTH:0];
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      ITER,
`ifdef CORDIC_GAIN_COMP_EN
      COMP,
`endif
      DONE
   } state_t;

   state_t state, state_nx;

   logic signed [W-1:0] x_q, y_q, z_q;
   logic signed [W-1:0] x_nx, y_nx, z_nx;
   logic signed [W-1:0] x_ext, y_ext, a_ext;
   logic [5:0]          iter_q;
   logic                zero_q;
   logic [W-1:0]        mag_q;
   logic signed [W-1:0] ang_q;
   logic                busy_c, done_c;
   logic [5:0]          count_c;

   assign x_ext = {{2{bus.x_in[BIT_WIDTH-1]}}, bus.x_in};
   assign y_ext = {{2{bus.y_in[BIT_WIDTH-1]}}, bus.y_in};
   assign a_ext = {2'b00, di_ei_result[63 -: BIT_WIDTH]};

`ifdef CORDIC_GAIN_COMP_EN
   logic signed [W-1:0] x_scaled;
   assign x_scaled = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      busy_c   = 1'b0;
      done_c   = 1'b0;
      count_c  = 6'd0;
      case (state)
         IDLE: begin
            if (bus.start) state_nx = ITER;
         end
         ITER: begin
            busy_c  = 1'b1;
            count_c = iter_q;
`ifdef CORDIC_GAIN_COMP_EN
            if (iter_q == LAST) state_nx = COMP;
`else
            if (iter_q == LAST) state_nx = DONE;
`endif
         end
`ifdef CORDIC_GAIN_COMP_EN
         COMP: begin
            busy_c   = 1'b1;
            state_nx = DONE;
         end
`endif
         DONE: begin
            busy_c   = 1'b1;
            done_c   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Micro-rotation drives y toward zero; shifts use the pre-update x/y.
   always_comb begin
      x_nx = x_q;
      y_nx = y_q;
      z_nx = z_q;
      if (!y_q[W-1]) begin
         x_nx = x_q + (y_q >>> iter_q);
         y_nx = y_q - (x_q >>> iter_q);
         z_nx = z_q + a_ext;
      end else begin
         x_nx = x_q - (y_q >>> iter_q);
         y_nx = y_q + (x_q >>> iter_q);
         z_nx = z_q - a_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q    <= '0;
         y_q    <= '0;
         z_q    <= '0;
         iter_q <= 6'd0;
         zero_q <= 1'b0;
         mag_q  <= '0;
         ang_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  iter_q <= 6'd0;
                  zero_q <= (bus.x_in == '0) && (bus.y_in == '0);
                  // Pre-rotate left-half-plane vectors by -/+90 deg so CORDIC converges.
                  if (!x_ext[W-1]) begin
                     x_q <= x_ext;
                     y_q <= y_ext;
                     z_q <= '0;
                  end else if (!y_ext[W-1]) begin
                     x_q <= y_ext;
                     y_q <= -x_ext;
                     z_q <= HALF_PI;
                  end else begin
                     x_q <= -y_ext;
                     y_q <= x_ext;
                     z_q <= -HALF_PI;
                  end
               end
            end
            ITER: begin
               x_q    <= x_nx;
               y_q    <= y_nx;
               z_q    <= z_nx;
               iter_q <= iter_q + 6'd1;
`ifndef CORDIC_GAIN_COMP_EN
               if (iter_q == LAST) begin
                  mag_q <= zero_q ? '0 : x_nx;
                  ang_q <= zero_q ? '0 : z_nx;
               end
`endif
            end
`ifdef CORDIC_GAIN_COMP_EN
            COMP: begin
               mag_q <= zero_q ? '0 : x_scaled;
               ang_q <= zero_q ? '0 : z_q;
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
   assign bus.mag_out   = mag_q;
   assign bus.angle_out = ang_q;
   assign count         = count_c;

endmodule

// File: tb/tb_cordic_vectoring_engine.sv
// Scoreboard bench for cordic_vectoring_engine: real-math atan2/magnitude model, random and directed vectors.
module tb_cordic_vectoring_engine;

   localparam int BW    = 32;
   localparam int ITERS = 32;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int  LAT     = ITERS + 2;
   localparam real MAG_REL = 5.0e-4;
`else
   localparam int  LAT     = ITERS + 1;
   localparam real MAG_REL = 1.0e-4;
`endif
   localparam longint ANG_TOL = 1024;

   typedef struct {
      longint ang;
      longint mag;
      longint ang_tol;
      longint mag_tol;
      int     t;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  count;
   logic [63:0] di_ei_result;
   logic [63:0] lut [64];
   real         kgain;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   exp_t        sb[$];
   exp_t        mon_e;

   cordic_vectoring_engine_if #(.BIT_WIDTH(BW)) bus();

   cordic_vectoring_engine #(.BIT_WIDTH(BW), .ITERATIONS(ITERS)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .count        (count),
      .di_ei_result (di_ei_result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign di_ei_result = lut[count];

   task automatic checkOutput(input string name, input longint act, input longint req, input longint tol);
      total++;
      if (act > req + tol || act < req - tol) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d required=%0d tol=%0d", name, act, req, tol);
      end
   endtask

   // Reference: ideal atan2 in angle LSBs and gain-scaled Euclidean magnitude.
   function automatic exp_t model(input longint x, input longint y, input int t);
      exp_t e;
      real  rx, ry, m;
      e.t = t;
      if (x == 0 && y == 0) begin
         e.ang = 0; e.mag = 0; e.ang_tol = 0; e.mag_tol = 0;
      end else begin
         rx = real'(x);
         ry = real'(y);
         m  = $sqrt(rx * rx + ry * ry) * kgain;
         e.ang     = longint'($atan2(ry, rx) * 2147483648.0);
         e.mag     = longint'(m);
         e.ang_tol = ANG_TOL;
         e.mag_tol = longint'(m * MAG_REL) + 2;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_done actual=1 required=0");
         end else begin
            mon_e = sb.pop_front();
            checkOutput("latency", longint'(cyc - mon_e.t), longint'(LAT), 0);
            checkOutput("angle_out", longint'(bus.angle_out), mon_e.ang, mon_e.ang_tol);
            checkOutput("mag_out", longint'(bus.mag_out), mon_e.mag, mon_e.mag_tol);
         end
      end
   end

   task automatic applyStimulus(input longint x, input longint y);
      @(negedge clk);
      bus.x_in  = x[31:0];
      bus.y_in  = y[31:0];
      bus.start = 1'b1;
      sb.push_back(model(x, y, cyc));
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("busy_iter", longint'(bus.busy), 1, 0);
      for (int i = 0; i < ITERS; i++) begin
         checkOutput("count_step", longint'(count), longint'(i), 0);
         @(negedge clk);
      end
      repeat (LAT - ITERS) @(negedge clk);
      checkOutput("idle_count", longint'(count), 0, 0);
      checkOutput("idle_busy", longint'(bus.busy), 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      real    p;
      longint rx, ry;
      int     c, tries;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.x_in  = '0;
      bus.y_in  = '0;
      p = 1.0;
      for (int i = 0; i < 64; i++) begin
         lut[i] = 64'(longint'($atan(p) * 9223372036854775808.0));
         p = p / 2.0;
      end
`ifdef CORDIC_GAIN_COMP_EN
      kgain = 1.0;
`else
      kgain = 1.0;
      p = 1.0;
      for (int i = 0; i < ITERS; i++) begin
         kgain = kgain * $sqrt(1.0 + p * p);
         p = p / 2.0;
      end
`endif

      repeat (3) @(negedge clk);
      checkOutput("rst_busy", longint'(bus.busy), 0, 0);
      checkOutput("rst_done", longint'(bus.done), 0, 0);
      checkOutput("rst_count", longint'(count), 0, 0);
      checkOutput("rst_mag", longint'(bus.mag_out), 0, 0);
      checkOutput("rst_angle", longint'(bus.angle_out), 0, 0);
      rst = 1'b0;

      $display("[TB] directed vectors");
      applyStimulus(64'sd268435456, 64'sd0);
      applyStimulus(64'sd268435456, 64'sd268435456);
      applyStimulus(-64'sd268435456, 64'sd0);
      applyStimulus(64'sd0, -64'sd268435456);
      applyStimulus(64'sd0, 64'sd0);
      applyStimulus(-64'sd2147483648, -64'sd2147483648);
      applyStimulus(64'sd2147483647, -64'sd2147483648);
      applyStimulus(-64'sd2147483648, 64'sd2147483647);

      $display("[TB] random vectors");
      for (int n = 0; n < 24; n++) begin
         tries = 0;
         do begin
            rx = longint'($signed($urandom));
            ry = longint'($signed($urandom));
            tries++;
         end while ((real'(rx) * real'(rx) + real'(ry) * real'(ry)) < 72057594037927936.0 && tries < 100);
         applyStimulus(rx, ry);
      end

      $display("[TB] start held high");
      @(negedge clk);
      c = cyc;
      bus.x_in  = 32'sd300000000;
      bus.y_in  = -32'sd123456789;
      bus.start = 1'b1;
      sb.push_back(model(64'sd300000000, -64'sd123456789, c));
      sb.push_back(model(64'sd300000000, -64'sd123456789, c + LAT + 1));
      repeat (LAT + 2) @(negedge clk);
      bus.start = 1'b0;
      repeat (LAT + 1) @(negedge clk);
      checkOutput("held_idle_busy", longint'(bus.busy), 0, 0);
      checkOutput("held_sb_drained", longint'(sb.size()), 0, 0);

      $display("[TB] reset mid-operation");
      @(negedge clk);
      bus.x_in  = 32'sd400000000;
      bus.y_in  = 32'sd500000000;
      bus.start = 1'b1;
      sb.push_back(model(64'sd400000000, 64'sd500000000, cyc));
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("count_before_abort", longint'(count), 10, 0);
      rst = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_busy", longint'(bus.busy), 0, 0);
      checkOutput("abort_done", longint'(bus.done), 0, 0);
      checkOutput("abort_count", longint'(count), 0, 0);
      checkOutput("abort_mag", longint'(bus.mag_out), 0, 0);
      checkOutput("abort_angle", longint'(bus.angle_out), 0, 0);
      repeat (LAT + 2) @(negedge clk);
      checkOutput("abort_still_idle", longint'(bus.busy), 0, 0);
      applyStimulus(64'sd268435456, 64'sd268435456);

      repeat (4) @(negedge clk);
      checkOutput("scoreboard_empty", longint'(sb.size()), 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
